// File: rtl/ddram_wr_combiner.sv
// ddram_wr_combiner: merges 32-bit lane writes into 64-bit qword writes,
// queues them in a small FIFO and presents them to DDRAM one at a time,
// stalling on DDRAM_BUSY.
module ddram_wr_combiner #(
   parameter int DEPTH_LOG2 = 4,
   parameter int TIMEOUT    = 4
) (
   input  logic        CLK_VIDEO,
   input  logic        RESET_N,
   input  logic        in_we,
   input  logic [28:0] in_addr,
   input  logic        in_hi,
   input  logic [31:0] in_data,
   input  logic        flush,
   input  logic        DDRAM_BUSY,
   output logic        DDRAM_CLK,
   output logic        DDRAM_WE,
   output logic [28:0] DDRAM_ADDR,
   output logic [63:0] DDRAM_DIN,
   output logic [7:0]  DDRAM_BE,
   output logic [7:0]  DDRAM_BURSTCNT,
   output logic        DDRAM_RD,
   output logic        idle,
   output logic        fifo_full,
   output logic        overflow
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [CNT_W-1:0]    IDLE_MAX = CNT_W'(TIMEOUT - 1);

   typedef struct packed {
      logic [28:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } wr_ent_t;

   assign DDRAM_CLK      = CLK_VIDEO;
   assign DDRAM_BURSTCNT = 8'd1;
   assign DDRAM_RD       = 1'b0;

   // holding register
   logic             hold_v, hold_v_n;
   logic [28:0]      hold_addr, hold_addr_n;
   logic [63:0]      hold_data, hold_data_n;
   logic [7:0]       hold_be, hold_be_n;
   logic [CNT_W-1:0] idle_cnt, cnt_n;
   logic             flush_pend, pend_n;
   logic             flush_eff;
   logic [63:0]      lane_data;
   logic [7:0]       lane_be;
   logic             push_v;
   wr_ent_t          push_ent;

   // FIFO
   wr_ent_t               mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  out_ready, pop, push_ok;

   assign lane_data = in_hi ? {in_data, 32'h0} : {32'h0, in_data};
   assign lane_be   = in_hi ? 8'hF0 : 8'h0F;
   // a flush seen together with a write is deferred one cycle so the write lands first
   assign flush_eff = flush | flush_pend;

   assign out_ready = !DDRAM_WE || !DDRAM_BUSY;
   assign pop       = out_ready && (count != '0);
   assign push_ok   = push_v && ((count != DEPTH_C) || pop);
   assign fifo_full = (count == DEPTH_C);
   assign idle      = !hold_v && (count == '0) && !DDRAM_WE;

   // next holding-register state: load, merge, push-on-miss, timeout and flush
   always_comb begin
      hold_v_n    = hold_v;
      hold_addr_n = hold_addr;
      hold_data_n = hold_data;
      hold_be_n   = hold_be;
      cnt_n       = idle_cnt;
      pend_n      = 1'b0;
      push_v      = 1'b0;
      push_ent    = {hold_addr, hold_data, hold_be};
      if (in_we) begin
         cnt_n  = '0;
         pend_n = flush_eff;
         if (hold_v && (in_addr == hold_addr)) begin
            if (in_hi) hold_data_n[63:32] = in_data;
            else       hold_data_n[31:0]  = in_data;
            hold_be_n = hold_be | lane_be;
         end else begin
            push_v      = hold_v;
            hold_v_n    = 1'b1;
            hold_addr_n = in_addr;
            hold_data_n = lane_data;
            hold_be_n   = lane_be;
         end
      end else if (hold_v) begin
         if (flush_eff || (idle_cnt == IDLE_MAX)) begin
            push_v   = 1'b1;
            hold_v_n = 1'b0;
            cnt_n    = '0;
         end else begin
            cnt_n = idle_cnt + 1'b1;
         end
      end
   end

   // holding register and idle counter state
   always_ff @(posedge CLK_VIDEO) begin
      if (!RESET_N) begin
         hold_v     <= 1'b0;
         hold_addr  <= '0;
         hold_data  <= '0;
         hold_be    <= '0;
         idle_cnt   <= '0;
         flush_pend <= 1'b0;
      end else begin
         hold_v     <= hold_v_n;
         hold_addr  <= hold_addr_n;
         hold_data  <= hold_data_n;
         hold_be    <= hold_be_n;
         idle_cnt   <= cnt_n;
         flush_pend <= pend_n;
      end
   end

   // FIFO storage; contents are don't-care once the pointers are reset
   always_ff @(posedge CLK_VIDEO) begin
      if (push_ok) mem[wr_ptr] <= push_ent;
   end

   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge CLK_VIDEO) begin
      if (!RESET_N) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_v && !push_ok) overflow <= 1'b1;
      end
   end

   // registered DDRAM request: hold while busy, reload on acceptance or when empty
   always_ff @(posedge CLK_VIDEO) begin
      if (!RESET_N) begin
         DDRAM_WE   <= 1'b0;
         DDRAM_ADDR <= '0;
         DDRAM_DIN  <= '0;
         DDRAM_BE   <= '0;
      end else if (out_ready) begin
         if (pop) begin
            DDRAM_WE                           <= 1'b1;
            {DDRAM_ADDR, DDRAM_DIN, DDRAM_BE}  <= mem[rd_ptr];
         end else begin
            DDRAM_WE <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_ddram_wr_combiner.sv
// tb_ddram_wr_combiner: directed stimulus, queue-based reference model checked
// every cycle, plus literal expectations for the key scenarios.
module tb_ddram_wr_combiner;
   localparam int DL2   = 4;
   localparam int TO    = 4;
   localparam int DEPTH = 1 << DL2;

   typedef struct packed {
      logic [28:0] addr;
      logic [63:0] data;
      logic [7:0]  be;
   } ent_t;

   logic        clk = 1'b0;
   logic        RESET_N, in_we, in_hi, flush, DDRAM_BUSY;
   logic [28:0] in_addr;
   logic [31:0] in_data;
   logic        DDRAM_CLK, DDRAM_WE, DDRAM_RD, idle, fifo_full, overflow;
   logic [28:0] DDRAM_ADDR;
   logic [63:0] DDRAM_DIN;
   logic [7:0]  DDRAM_BE, DDRAM_BURSTCNT;

   always #5 clk = ~clk;

   ddram_wr_combiner #(.DEPTH_LOG2(DL2), .TIMEOUT(TO)) dut (
      .CLK_VIDEO(clk), .RESET_N(RESET_N), .in_we(in_we), .in_addr(in_addr),
      .in_hi(in_hi), .in_data(in_data), .flush(flush), .DDRAM_BUSY(DDRAM_BUSY),
      .DDRAM_CLK(DDRAM_CLK), .DDRAM_WE(DDRAM_WE), .DDRAM_ADDR(DDRAM_ADDR),
      .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .DDRAM_BURSTCNT(DDRAM_BURSTCNT),
      .DDRAM_RD(DDRAM_RD), .idle(idle), .fifo_full(fifo_full), .overflow(overflow));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // reference model state
   logic        m_hv, m_pend, m_we, m_ovf;
   logic [28:0] m_ha;
   logic [63:0] m_hd;
   logic [7:0]  m_hb;
   int          m_cnt;
   ent_t        m_out;
   ent_t        mq[$];

   // observed DDRAM acceptances
   ent_t        log_q[$];
   int          acc_cyc[$];
   int          cyc_no = 0;

   always @(posedge clk) begin : mdl
      logic fe, pv;
      ent_t pe;
      cyc_no++;
      if (RESET_N && DDRAM_WE && !DDRAM_BUSY) begin
         log_q.push_back({DDRAM_ADDR, DDRAM_DIN, DDRAM_BE});
         acc_cyc.push_back(cyc_no);
      end
      if (!RESET_N) begin
         m_hv = 0; m_pend = 0; m_we = 0; m_ovf = 0; m_cnt = 0;
         m_ha = '0; m_hd = '0; m_hb = '0; m_out = '0;
         mq.delete();
      end else begin
         // output side first: it sees the queue as it was before this edge
         if (!m_we || !DDRAM_BUSY) begin
            if (mq.size() > 0) begin m_out = mq.pop_front(); m_we = 1; end
            else m_we = 0;
         end
         fe = flush || m_pend;
         pv = 0;
         pe = {m_ha, m_hd, m_hb};
         if (in_we) begin
            m_pend = fe;
            m_cnt  = 0;
            if (m_hv && in_addr == m_ha) begin
               if (in_hi) m_hd[63:32] = in_data; else m_hd[31:0] = in_data;
               m_hb = m_hb | (in_hi ? 8'hF0 : 8'h0F);
            end else begin
               pv   = m_hv;
               m_hv = 1;
               m_ha = in_addr;
               m_hd = in_hi ? {in_data, 32'h0} : {32'h0, in_data};
               m_hb = in_hi ? 8'hF0 : 8'h0F;
            end
         end else begin
            m_pend = 0;
            if (m_hv) begin
               m_cnt++;
               if (fe || m_cnt == TO) begin pv = 1; m_hv = 0; m_cnt = 0; end
            end
         end
         if (pv) begin
            if (mq.size() < DEPTH) mq.push_back(pe);
            else m_ovf = 1;
         end
      end
      #1;
      chk("we",    64'(DDRAM_WE),   64'(m_we));
      chk("addr",  64'(DDRAM_ADDR), 64'(m_out.addr));
      chk("din",   DDRAM_DIN,       m_out.data);
      chk("be",    64'(DDRAM_BE),   64'(m_out.be));
      chk("idle",  64'(idle),       64'(!m_hv && mq.size() == 0 && !m_we));
      chk("full",  64'(fifo_full),  64'(mq.size() == DEPTH));
      chk("ovf",   64'(overflow),   64'(m_ovf));
      chk("burst", 64'(DDRAM_BURSTCNT), 64'd1);
      chk("rd",    64'(DDRAM_RD),   64'd0);
      chk("ddclk", 64'(DDRAM_CLK),  64'(clk));
   end

   task automatic wr(input logic [28:0] a, input logic hi, input logic [31:0] d);
      in_we = 1; in_addr = a; in_hi = hi; in_data = d;
      @(negedge clk);
      in_we = 0;
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (!idle && n < 200) begin @(negedge clk); n++; end
      chk({nm, " idle wait"}, 64'(n < 200), 64'd1);
   endtask

   task automatic clr_log();
      log_q.delete();
      acc_cyc.delete();
   endtask

   initial begin
      int n;
      RESET_N = 0; in_we = 0; in_addr = '0; in_hi = 0; in_data = '0;
      flush = 0; DDRAM_BUSY = 0;
      repeat (2) @(negedge clk);
      // a write during reset must be ignored
      in_we = 1; in_addr = 29'h7; in_data = 32'hDEAD;
      @(negedge clk);
      in_we = 0;
      chk("rst we",   64'(DDRAM_WE), 64'd0);
      chk("rst idle", 64'(idle),     64'd1);
      chk("rst ovf",  64'(overflow), 64'd0);
      chk("rst full", 64'(fifo_full),64'd0);
      RESET_N = 1;
      @(negedge clk);
      chk("post rst idle", 64'(idle), 64'd1);

      // lanes merge into one qword
      clr_log();
      wr(29'h100, 0, 32'h11223344);
      wr(29'h100, 1, 32'h55667788);
      n = 0;
      while (!DDRAM_WE && n < 20) begin @(posedge clk); #1; n++; end
      chk("merge latency", 64'(n), 64'(TO + 1));
      chk("merge addr", 64'(DDRAM_ADDR), 64'h100);
      chk("merge din",  DDRAM_DIN, 64'h5566778811223344);
      chk("merge be",   64'(DDRAM_BE), 64'hFF);
      chk("model din",  m_out.data, 64'h5566778811223344);
      @(negedge clk);
      wait_idle("merge");
      chk("merge count", 64'(log_q.size()), 64'd1);

      // different addresses stay separate, in order
      clr_log();
      wr(29'h100, 0, 32'hA1);
      wr(29'h101, 0, 32'hB2);
      wait_idle("nomerge");
      chk("nomerge count", 64'(log_q.size()), 64'd2);
      if (log_q.size() == 2) begin
         chk("nomerge a0",  64'(log_q[0].addr), 64'h100);
         chk("nomerge be0", 64'(log_q[0].be),   64'h0F);
         chk("nomerge d0",  log_q[0].data,      64'hA1);
         chk("nomerge a1",  64'(log_q[1].addr), 64'h101);
         chk("nomerge be1", 64'(log_q[1].be),   64'h0F);
      end

      // a write arriving on the timeout cycle still merges
      clr_log();
      wr(29'h600, 0, 32'h1);
      repeat (TO - 1) @(negedge clk);
      wr(29'h600, 1, 32'h2);
      wait_idle("boundary");
      chk("boundary count", 64'(log_q.size()), 64'd1);
      if (log_q.size() == 1) begin
         chk("boundary be", 64'(log_q[0].be), 64'hFF);
         chk("boundary d",  log_q[0].data,    64'h0000000200000001);
      end

      // busy stalls the output with three entries queued
      clr_log();
      DDRAM_BUSY = 1;
      wr(29'h200, 0, 32'h1);
      wr(29'h201, 0, 32'h2);
      wr(29'h202, 0, 32'h3);
      flush = 1;
      @(negedge clk);
      flush = 0;
      repeat (10) begin
         @(negedge clk);
         chk("stall we",   64'(DDRAM_WE),   64'd1);
         chk("stall addr", 64'(DDRAM_ADDR), 64'h200);
      end
      DDRAM_BUSY = 0;
      wait_idle("stall");
      chk("stall count", 64'(log_q.size()), 64'd3);
      if (log_q.size() == 3) begin
         chk("stall gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
         chk("stall gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd1);
         chk("stall a2",   64'(log_q[2].addr), 64'h202);
      end

      // overflow: 18 writes while busy, 17 retained
      clr_log();
      DDRAM_BUSY = 1;
      for (int i = 0; i < 18; i++) wr(29'h300 + 29'(i), 0, 32'(i));
      repeat (TO + 3) @(negedge clk);
      chk("ovf full", 64'(fifo_full), 64'd1);
      chk("ovf set",  64'(overflow),  64'd1);
      chk("model ovf",64'(m_ovf),     64'd1);
      DDRAM_BUSY = 0;
      wait_idle("ovf");
      chk("ovf count", 64'(log_q.size()), 64'd17);
      if (log_q.size() == 17) begin
         chk("ovf first", 64'(log_q[0].addr),  64'h300);
         chk("ovf last",  64'(log_q[16].addr), 64'h310);
      end
      chk("ovf sticky", 64'(overflow), 64'd1);

      // flush one cycle after a single write
      clr_log();
      wr(29'h400, 1, 32'hCAFE);
      flush = 1;
      @(posedge clk); #1;
      chk("flush +1", 64'(DDRAM_WE), 64'd0);
      @(posedge clk); #1;
      chk("flush +2", 64'(DDRAM_WE), 64'd1);
      @(negedge clk);
      flush = 0;
      wait_idle("flush");

      // flush together with a write pushes on the following cycle
      flush = 1;
      wr(29'h410, 0, 32'h5);
      flush = 0;
      @(posedge clk); #1;
      chk("wflush +1", 64'(DDRAM_WE), 64'd0);
      @(posedge clk); #1;
      chk("wflush +2", 64'(DDRAM_WE), 64'd1);
      @(negedge clk);
      wait_idle("wflush");

      // reset during a stalled request
      DDRAM_BUSY = 1;
      wr(29'h500, 0, 32'h9);
      flush = 1;
      @(negedge clk);
      flush = 0;
      @(negedge clk);
      chk("pre rst we", 64'(DDRAM_WE), 64'd1);
      RESET_N = 0;
      @(posedge clk); #1;
      chk("mid rst we",   64'(DDRAM_WE), 64'd0);
      chk("mid rst idle", 64'(idle),     64'd1);
      chk("mid rst ovf",  64'(overflow), 64'd0);
      @(negedge clk);
      RESET_N = 1;
      DDRAM_BUSY = 0;
      clr_log();
      repeat (6) @(negedge clk);
      chk("post rst writes", 64'(log_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
